gx4000_asic_page: RTL and testbench
===================================

// Module: gx4000_asic_page
// PURPOSE
//  Downstream consumer of the ASIC unlock stage (its asic_valid output).
//  Once the ASIC is unlocked, decodes RMR2 I/O writes to map the ASIC register page into 0x4000-0x7FFF.
//  While the page is mapped, it holds the Plus register subset: palette, PRI, SPLT, SSA, SSCR and IVR.
//  It drives the ROM-map controls, a palette read port for video, and CPU read-back data.
// PARAMETERS
//  PAL_ENTRIES  32  palette entries (index width = 5)
// PORTS
//  clk_sys        in   1   system clock
//  reset          in   1   reset, asynchronous, active-high
//  plus_mode      in   1   Plus/GX4000 mode enable
//  asic_valid     in   1   ASIC unlocked, from the unlock stage
//  cpu_addr       in   16  CPU address bus
//  cpu_data_in    in   8   CPU write data
//  cpu_wr         in   1   CPU write strobe (level)
//  cpu_rd         in   1   CPU read strobe (level)
//  cpu_mreq       in   1   memory cycle qualifier
//  cpu_iorq       in   1   I/O cycle qualifier
//  cpu_data_out   out  8   read-back data
//  cpu_data_oe    out  1   read-back drive enable
//  asic_page_en   out  1   ASIC page mapped at 0x4000-0x7FFF; memory mux blocks RAM writes there
//  lower_rom_loc  out  2   RMR2[4:3] lower ROM location (0=0000,1=4000,2=8000)
//  lower_rom_bank out  3   RMR2[2:0] cartridge bank for lower ROM
//  pal_rd_idx     in   5   video palette index
//  pal_rd_data    out  12  palette entry {G[3:0],R[3:0],B[3:0]}, 1-cycle latency
//  pri_line       out  8   programmable raster interrupt line (0x6800)
//  splt_line      out  8   split-screen line (0x6801)
//  ssa            out  16  split start address (0x6802 hi, 0x6803 lo)
//  sscr           out  8   soft-scroll control (0x6804)
//  ivr            out  8   interrupt vector (0x6805)
// BEHAVIOUR
//  - Reset (async): all outputs and registers are 0. Palette RAM is cleared to 0. Edge registers are cleared.
//  - Strobe detection: registered prev cpu_wr/cpu_rd. Exactly one action per rising edge.
//    The action takes effect on the edge detected, so outputs update one clk_sys later.
//  - RMR2:
//    - Trigger: wr edge & cpu_iorq & cpu_addr[15:8]==0x7F & cpu_data_in[7:5]==3'b101 & plus_mode & asic_valid.
//    - Loads lower_rom_loc = data[4:3] and lower_rom_bank = data[2:0].
//    - asic_page_en = (data[4:3]==2'b11).
//    - loc code 3 leaves lower_rom_loc = 3; the ROM mux treats 3 as "lower ROM at 0000".
//  - State: PAGE_OFF <-> PAGE_ON.
//    - Entry to PAGE_ON: RMR2 with loc=3.
//    - Exit to PAGE_OFF: RMR2 with loc!=3, asic_valid low, or plus_mode low.
//    - The exit is applied on the next clk_sys. Register contents are retained.
//  - Memory writes: accepted only when asic_page_en & wr edge & cpu_mreq & addr in 0x4000-0x7FFF.
//    - 0x6400-0x643F: entry = addr[5:1].
//      - Even address: bits[7:0] = data (R,B).
//      - Odd address: bits[11:8] = data[3:0]; data[7:4] is discarded.
//    - 0x6800-0x6805: PRI, SPLT, SSA hi, SSA lo, SSCR, IVR.
//    - Any other page address: write ignored.
//  - Reads:
//    - cpu_data_oe = cpu_rd & cpu_mreq & asic_page_en & addr in 0x4000-0x7FFF (combinational).
//    - cpu_data_out is registered on the rd edge and held while cpu_rd is high. It is 0 when oe is low.
//    - Registers 0x6800-0x6805 are write-only and read 0xFF. Unmapped page addresses read 0xFF.
//  - Video port: pal_rd_data <= pal[pal_rd_idx] each clk.
//    - A write to the same index in the same cycle returns the old value (read-before-write).
//  - Simultaneous: an RMR2 disabling the page and a memory write are mutually exclusive by strobe (iorq vs mreq).
//    An asic_valid fall in the same cycle as a memory write: the write is still accepted (page_en is still 1).
// CONFIGURATION
//  ASIC_PAL_READBACK_EN defined:
//    - Palette addresses read back their stored value: even -> bits[7:0], odd -> {4'h0, bits[11:8]}.
//  Not defined:
//    - Palette reads return 0xFF. No CPU read port on the palette RAM; only the video port exists.
// TESTING
//  1. asic_valid=1, I/O wr 0x7F00=0xB8 -> next clk: asic_page_en=1, lower_rom_loc=3, lower_rom_bank=0.
//  2. asic_valid=0, I/O wr 0x7F00=0xB8 -> asic_page_en, lower_rom_loc and lower_rom_bank all stay 0.
//  3. Page on: mem wr 0x6402=0x5A, 0x6403=0xF7; pal_rd_idx=1 -> pal_rd_data=0x75A one clk later.
//  4. Page on: wr 0x6800=0x40, 0x6802=0x12, 0x6803=0x34 -> pri_line=0x40, ssa=0x1234.
//     Page off: same writes -> values unchanged.
//  5. Page on, drop asic_valid -> asic_page_en=0 next clk, ssa still 0x1234.
//     Assert reset mid-write -> all outputs 0 immediately.
//  6. Read 0x6402: with ASIC_PAL_READBACK_EN -> 0x5A, oe=1; without it -> 0xFF.
//     Read 0x6800 -> 0xFF in both builds.

Source files
------------

// File: rtl/gx4000_asic_page.sv
// ASIC register page for the Plus/GX4000. RMR2 maps the page at 0x4000-0x7FFF.
// The page holds the palette, PRI, SPLT, SSA, SSCR and IVR. Define ASIC_PAL_READBACK_EN to let the CPU read the palette back.
module gx4000_asic_page #(
   parameter int PAL_ENTRIES = 32
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        plus_mode,
   input  logic        asic_valid,
   input  logic [15:0] cpu_addr,
   input  logic [7:0]  cpu_data_in,
   input  logic        cpu_wr,
   input  logic        cpu_rd,
   input  logic        cpu_mreq,
   input  logic        cpu_iorq,
   output logic [7:0]  cpu_data_out,
   output logic        cpu_data_oe,
   output logic        asic_page_en,
   output logic [1:0]  lower_rom_loc,
   output logic [2:0]  lower_rom_bank,
   input  logic [4:0]  pal_rd_idx,
   output logic [11:0] pal_rd_data,
   output logic [7:0]  pri_line,
   output logic [7:0]  splt_line,
   output logic [15:0] ssa,
   output logic [7:0]  sscr,
   output logic [7:0]  ivr
);
   localparam int IDX_W = $clog2(PAL_ENTRIES);

   typedef enum logic {PAGE_OFF, PAGE_ON} page_t;

   page_t       r_state, w_state_nxt;
   logic        r_wr_prev, r_rd_prev;
   logic [1:0]  r_rom_loc;
   logic [2:0]  r_rom_bank;
   logic [11:0] r_pal [PAL_ENTRIES];
   logic [11:0] r_pal_rd;
   logic [7:0]  r_pri, r_splt, r_ssa_hi, r_ssa_lo, r_sscr, r_ivr;
   logic [7:0]  r_rd_data;

   logic             w_wr_edge, w_rd_edge, w_rmr2, w_in_page, w_mem_wr;
   logic             w_pal_hit, w_reg_hit;
   logic [IDX_W-1:0] w_pal_idx;
   logic [7:0]       w_rd_val;

   assign w_wr_edge = cpu_wr & ~r_wr_prev;
   assign w_rd_edge = cpu_rd & ~r_rd_prev;
   assign w_rmr2    = w_wr_edge & cpu_iorq & (cpu_addr[15:8] == 8'h7F) &
                      (cpu_data_in[7:5] == 3'b101) & plus_mode & asic_valid;
   assign w_in_page = (cpu_addr[15:14] == 2'b01);
   // Uses the current page state, so a write racing an asic_valid fall still lands.
   assign w_mem_wr  = asic_page_en & w_wr_edge & cpu_mreq & w_in_page;
   assign w_pal_hit = (cpu_addr[15:6] == 10'h190);
   assign w_reg_hit = (cpu_addr[15:3] == 13'h0D00) & (cpu_addr[2:0] <= 3'd5);
   assign w_pal_idx = cpu_addr[IDX_W:1];

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) r_state <= PAGE_OFF;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (w_rmr2)
         w_state_nxt = (cpu_data_in[4:3] == 2'b11) ? PAGE_ON : PAGE_OFF;
      else if (!asic_valid || !plus_mode)
         w_state_nxt = PAGE_OFF;
   end

   assign asic_page_en = (r_state == PAGE_ON);

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         r_wr_prev  <= 1'b0;
         r_rd_prev  <= 1'b0;
         r_rom_loc  <= 2'd0;
         r_rom_bank <= 3'd0;
      end else begin
         r_wr_prev <= cpu_wr;
         r_rd_prev <= cpu_rd;
         if (w_rmr2) begin
            r_rom_loc  <= cpu_data_in[4:3];
            r_rom_bank <= cpu_data_in[2:0];
         end
      end
   end

   // The video read samples the array before this edge's write, giving read-before-write.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < PAL_ENTRIES; i++) r_pal[i] <= 12'h000;
         r_pal_rd <= 12'h000;
      end else begin
         r_pal_rd <= r_pal[pal_rd_idx];
         if (w_mem_wr && w_pal_hit) begin
            if (cpu_addr[0]) r_pal[w_pal_idx][11:8] <= cpu_data_in[3:0];
            else             r_pal[w_pal_idx][7:0]  <= cpu_data_in;
         end
      end
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         r_pri    <= 8'h00;
         r_splt   <= 8'h00;
         r_ssa_hi <= 8'h00;
         r_ssa_lo <= 8'h00;
         r_sscr   <= 8'h00;
         r_ivr    <= 8'h00;
      end else if (w_mem_wr && w_reg_hit) begin
         case (cpu_addr[2:0])
            3'd0:    r_pri    <= cpu_data_in;
            3'd1:    r_splt   <= cpu_data_in;
            3'd2:    r_ssa_hi <= cpu_data_in;
            3'd3:    r_ssa_lo <= cpu_data_in;
            3'd4:    r_sscr   <= cpu_data_in;
            default: r_ivr    <= cpu_data_in;
         endcase
      end
   end

   always_comb begin
      w_rd_val = 8'hFF;
`ifdef ASIC_PAL_READBACK_EN
      if (w_pal_hit)
         w_rd_val = cpu_addr[0] ? {4'h0, r_pal[w_pal_idx][11:8]} : r_pal[w_pal_idx][7:0];
`endif
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset)          r_rd_data <= 8'h00;
      else if (w_rd_edge) r_rd_data <= w_rd_val;
   end

   assign cpu_data_oe    = cpu_rd & cpu_mreq & asic_page_en & w_in_page;
   assign cpu_data_out   = cpu_data_oe ? r_rd_data : 8'h00;
   assign lower_rom_loc  = r_rom_loc;
   assign lower_rom_bank = r_rom_bank;
   assign pal_rd_data    = r_pal_rd;
   assign pri_line       = r_pri;
   assign splt_line      = r_splt;
   assign ssa            = {r_ssa_hi, r_ssa_lo};
   assign sscr           = r_sscr;
   assign ivr            = r_ivr;
endmodule

// File: tb/tb_gx4000_asic_page.sv
// Bench for gx4000_asic_page: a transaction-level model is checked every cycle,
// and directed vectors carry hand-computed expectations.
module tb_gx4000_asic_page;
   logic        clk_sys = 1'b0;
   logic        reset, plus_mode, asic_valid, cpu_wr, cpu_rd, cpu_mreq, cpu_iorq;
   logic [15:0] cpu_addr;
   logic [7:0]  cpu_data_in, cpu_data_out, pri_line, splt_line, sscr, ivr;
   logic        cpu_data_oe, asic_page_en;
   logic [1:0]  lower_rom_loc;
   logic [2:0]  lower_rom_bank;
   logic [4:0]  pal_rd_idx;
   logic [11:0] pal_rd_data;
   logic [15:0] ssa;

   int n_tot = 0;
   int n_bad = 0;

   gx4000_asic_page dut (
      .clk_sys(clk_sys), .reset(reset), .plus_mode(plus_mode), .asic_valid(asic_valid),
      .cpu_addr(cpu_addr), .cpu_data_in(cpu_data_in), .cpu_wr(cpu_wr), .cpu_rd(cpu_rd),
      .cpu_mreq(cpu_mreq), .cpu_iorq(cpu_iorq), .cpu_data_out(cpu_data_out),
      .cpu_data_oe(cpu_data_oe), .asic_page_en(asic_page_en), .lower_rom_loc(lower_rom_loc),
      .lower_rom_bank(lower_rom_bank), .pal_rd_idx(pal_rd_idx), .pal_rd_data(pal_rd_data),
      .pri_line(pri_line), .splt_line(splt_line), .ssa(ssa), .sscr(sscr), .ivr(ivr)
   );

   always #5 clk_sys = ~clk_sys;

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_tot++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: each transaction's effect, expressed on addresses and stored values.
   logic        m_page, m_wrp, m_rdp;
   logic [1:0]  m_loc;
   logic [2:0]  m_bank;
   logic [11:0] m_pal [32];
   logic [11:0] m_pal_rd;
   logic [7:0]  m_reg [6];
   logic [7:0]  m_rd;

   always @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         m_page = 0; m_wrp = 0; m_rdp = 0; m_loc = 0; m_bank = 0; m_pal_rd = 0; m_rd = 0;
         for (int i = 0; i < 32; i++) m_pal[i] = 0;
         for (int i = 0; i < 6; i++) m_reg[i] = 0;
      end else begin
         automatic logic wr_e = cpu_wr && !m_wrp;
         automatic logic rd_e = cpu_rd && !m_rdp;
         automatic logic pg_next = m_page;
         automatic int   ent = (int'(cpu_addr) - 'h6400) / 2;
         automatic logic is_pal = cpu_addr >= 16'h6400 && cpu_addr <= 16'h643F;
         m_pal_rd = m_pal[pal_rd_idx];
         if (rd_e) begin
            m_rd = 8'hFF;
`ifdef ASIC_PAL_READBACK_EN
            if (is_pal) m_rd = (cpu_addr % 2 == 1) ? {4'h0, m_pal[ent][11:8]} : m_pal[ent][7:0];
`endif
         end
         if (wr_e && cpu_iorq && cpu_addr[15:8] == 8'h7F && cpu_data_in[7:5] == 3'b101 &&
             plus_mode && asic_valid) begin
            m_loc = cpu_data_in[4:3]; m_bank = cpu_data_in[2:0];
            pg_next = (m_loc == 3);
         end else if (!asic_valid || !plus_mode) pg_next = 0;
         if (m_page && wr_e && cpu_mreq && cpu_addr >= 16'h4000 && cpu_addr <= 16'h7FFF) begin
            if (is_pal) begin
               if (cpu_addr % 2 == 1) m_pal[ent][11:8] = cpu_data_in[3:0];
               else                   m_pal[ent][7:0]  = cpu_data_in;
            end else if (cpu_addr >= 16'h6800 && cpu_addr <= 16'h6805)
               m_reg[cpu_addr - 16'h6800] = cpu_data_in;
         end
         m_page = pg_next; m_wrp = cpu_wr; m_rdp = cpu_rd;
      end
   end

   always @(negedge clk_sys) begin
      if (!reset) begin
         automatic logic oe = cpu_rd && cpu_mreq && m_page && cpu_addr >= 16'h4000 && cpu_addr <= 16'h7FFF;
         chk("page_en", 16'(asic_page_en), 16'(m_page));
         chk("rom_loc", 16'(lower_rom_loc), 16'(m_loc));
         chk("rom_bank", 16'(lower_rom_bank), 16'(m_bank));
         chk("pal_rd_data", 16'(pal_rd_data), 16'(m_pal_rd));
         chk("pri", 16'(pri_line), 16'(m_reg[0]));
         chk("splt", 16'(splt_line), 16'(m_reg[1]));
         chk("ssa", ssa, {m_reg[2], m_reg[3]});
         chk("sscr", 16'(sscr), 16'(m_reg[4]));
         chk("ivr", 16'(ivr), 16'(m_reg[5]));
         chk("oe", 16'(cpu_data_oe), 16'(oe));
         chk("data_out", 16'(cpu_data_out), oe ? 16'(m_rd) : 16'h0);
      end
   end

   task automatic io_wr(input logic [15:0] a, input logic [7:0] d);
      cpu_addr = a; cpu_data_in = d; cpu_iorq = 1; cpu_wr = 1;
      @(posedge clk_sys); #1;
      cpu_wr = 0; cpu_iorq = 0;
      @(posedge clk_sys); #1;
   endtask

   task automatic mem_wr(input logic [15:0] a, input logic [7:0] d);
      cpu_addr = a; cpu_data_in = d; cpu_mreq = 1; cpu_wr = 1;
      @(posedge clk_sys); #1;
      cpu_wr = 0; cpu_mreq = 0;
      @(posedge clk_sys); #1;
   endtask

   task automatic mem_rd(input string nm, input logic [15:0] a, input logic [7:0] d, input logic oe);
      cpu_addr = a; cpu_mreq = 1; cpu_rd = 1;
      @(posedge clk_sys); #1;
      chk({nm, "_data"}, 16'(cpu_data_out), 16'(d));
      chk({nm, "_oe"}, 16'(cpu_data_oe), 16'(oe));
      @(posedge clk_sys); #1;
      chk({nm, "_hold"}, 16'(cpu_data_out), 16'(d));
      cpu_rd = 0; cpu_mreq = 0;
      @(posedge clk_sys); #1;
   endtask

   localparam logic [7:0] PAL_LO = `ifdef ASIC_PAL_READBACK_EN 8'h5A `else 8'hFF `endif;
   localparam logic [7:0] PAL_HI = `ifdef ASIC_PAL_READBACK_EN 8'h07 `else 8'hFF `endif;

   initial begin
      reset = 1; plus_mode = 0; asic_valid = 0; cpu_wr = 0; cpu_rd = 0; cpu_mreq = 0;
      cpu_iorq = 0; cpu_addr = 0; cpu_data_in = 0; pal_rd_idx = 0;
      repeat (3) @(posedge clk_sys);
      #1 reset = 0;
      chk("rst_page_en", 16'(asic_page_en), 16'h0);
      chk("rst_ssa", ssa, 16'h0);
      chk("rst_pal", 16'(pal_rd_data), 16'h0);

      plus_mode = 1;
      io_wr(16'h7F00, 8'hB8);
      chk("locked_page", 16'(asic_page_en), 16'h0);
      chk("locked_loc", 16'(lower_rom_loc), 16'h0);

      asic_valid = 1;
      io_wr(16'h7F00, 8'hB8);
      chk("unlock_page", 16'(asic_page_en), 16'h1);
      chk("unlock_loc", 16'(lower_rom_loc), 16'h3);
      chk("unlock_bank", 16'(lower_rom_bank), 16'h0);

      mem_wr(16'h6402, 8'h5A);
      mem_wr(16'h6403, 8'hF7);
      pal_rd_idx = 1;
      @(posedge clk_sys); #1;
      chk("pal1", 16'(pal_rd_data), 16'h075A);
      mem_wr(16'h643E, 8'hC3);
      mem_wr(16'h643F, 8'h2E);
      mem_wr(16'h6440, 8'h11);
      pal_rd_idx = 31;
      @(posedge clk_sys); #1;
      chk("pal31", 16'(pal_rd_data), 16'h0EC3);

      mem_wr(16'h6800, 8'h40);
      mem_wr(16'h6802, 8'h12);
      mem_wr(16'h6803, 8'h34);
      mem_wr(16'h6805, 8'hEE);
      mem_wr(16'h6806, 8'h99);
      chk("pri_on", 16'(pri_line), 16'h40);
      chk("ssa_on", ssa, 16'h1234);
      chk("ivr_on", 16'(ivr), 16'hEE);

      mem_rd("rd6402", 16'h6402, PAL_LO, 1);
      mem_rd("rd6403", 16'h6403, PAL_HI, 1);
      mem_rd("rd6800", 16'h6800, 8'hFF, 1);
      mem_rd("rd5000", 16'h5000, 8'hFF, 1);

      io_wr(16'h7F00, 8'hA4);
      chk("off_page", 16'(asic_page_en), 16'h0);
      chk("off_bank", 16'(lower_rom_bank), 16'h4);
      mem_wr(16'h6800, 8'h55);
      mem_wr(16'h6802, 8'hAB);
      chk("pri_off", 16'(pri_line), 16'h40);
      chk("ssa_off", ssa, 16'h1234);
      mem_rd("rd_off", 16'h6402, 8'h00, 0);

      io_wr(16'h7F00, 8'hB9);
      asic_valid = 0;
      @(posedge clk_sys); #1;
      chk("drop_page", 16'(asic_page_en), 16'h0);
      chk("drop_ssa", ssa, 16'h1234);
      chk("drop_bank", 16'(lower_rom_bank), 16'h1);

      asic_valid = 1;
      io_wr(16'h7F00, 8'hB8);
      cpu_addr = 16'h6804; cpu_data_in = 8'h77; cpu_mreq = 1; cpu_wr = 1; asic_valid = 0;
      @(posedge clk_sys); #1;
      cpu_wr = 0; cpu_mreq = 0;
      chk("race_sscr", 16'(sscr), 16'h77);
      chk("race_page", 16'(asic_page_en), 16'h0);

      asic_valid = 1;
      io_wr(16'h7F00, 8'hB8);
      plus_mode = 0;
      @(posedge clk_sys); #1;
      chk("plus_off_page", 16'(asic_page_en), 16'h0);
      plus_mode = 1;

      io_wr(16'h7F00, 8'hB8);
      cpu_addr = 16'h6801; cpu_data_in = 8'h33; cpu_mreq = 1; cpu_wr = 1;
      #2 reset = 1;
      #1;
      chk("rst_mid_page", 16'(asic_page_en), 16'h0);
      chk("rst_mid_loc", 16'(lower_rom_loc), 16'h0);
      chk("rst_mid_pri", 16'(pri_line), 16'h0);
      chk("rst_mid_ssa", ssa, 16'h0);
      chk("rst_mid_pal", 16'(pal_rd_data), 16'h0);
      cpu_wr = 0; cpu_mreq = 0;
      @(posedge clk_sys); #1 reset = 0;
      pal_rd_idx = 1;
      @(posedge clk_sys); #1;
      chk("rst_pal_clr", 16'(pal_rd_data), 16'h0);
      chk("rst_splt", 16'(splt_line), 16'h0);

      @(posedge clk_sys); #1;
      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end
endmodule
